// File: rtl/frq_div_pkg.sv
//------------------------------------------------------------------------------
// Module  : frq_div_pkg
// Purpose : Shared constants and types for the programmable frequency divider.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package frq_div_pkg;

   localparam int unsigned c_CNT_W    = 16;
   localparam int unsigned c_DEF_DIV  = 9;
   localparam int unsigned c_NCH_MAX  = 16;
   localparam int unsigned c_CH_IDX_W = $clog2(c_NCH_MAX);

   typedef logic [c_CH_IDX_W-1:0] ch_idx_t;

endpackage : frq_div_pkg

`default_nettype wire

// File: rtl/frq_div_ch.sv
//------------------------------------------------------------------------------
// Module  : frq_div_ch
// Purpose : One divider channel with shadowed divisor, tick pulse and square out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frq_div_ch
   import frq_div_pkg::*;
#(
   parameter int unsigned CNT_W   = c_CNT_W,
   parameter int unsigned DEF_DIV = c_DEF_DIV
) (
   input  logic             mclk,
   input  logic             reset,
   input  logic             sync_i,
   input  logic             en_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] val_i,
   output logic             tick_o,
   output logic             sq_o,
   output logic             pend_o
);

   localparam logic [CNT_W-1:0] c_DEF = CNT_W'(DEF_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic             w_wrap;

   assign w_wrap = (cnt_q == act_q);

   always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      sq_d   = sq_q;

      if (sync_i) begin
         cnt_d  = '0;
         sq_d   = 1'b0;
         pend_d = 1'b0;
         if (pend_q) begin
            act_d = shd_q;
         end
      end else if (!en_i) begin
         // An idle channel has no wrap to wait for, so take the new divisor now.
         if (pend_q) begin
            act_d  = shd_q;
            cnt_d  = '0;
            pend_d = 1'b0;
         end
      end else if (w_wrap) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         sq_d   = ~sq_q;
         if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // A write always lands in the shadow and waits for a later apply point.
      if (wr_i) begin
         shd_d  = val_i;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         act_q  <= c_DEF;
         shd_q  <= c_DEF;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;
   assign pend_o = pend_q;

endmodule : frq_div_ch

`default_nettype wire

// File: rtl/frq_div_prog.sv
//------------------------------------------------------------------------------
// Module  : frq_div_prog
// Purpose : Multi-channel programmable divider with shared divisor write bus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frq_div_prog
   import frq_div_pkg::*;
#(
   parameter int unsigned NCH     = 4,
   parameter int unsigned CNT_W   = c_CNT_W,
   parameter int unsigned DEF_DIV = c_DEF_DIV
) (
   input  logic                  mclk,
   input  logic                  reset,
   input  logic                  sync_i,
   input  logic [NCH-1:0]        ch_en_i,
   input  logic                  div_wr_i,
   input  logic [c_CH_IDX_W-1:0] div_ch_i,
   input  logic [CNT_W-1:0]      div_val_i,
   output logic [NCH-1:0]        tick_o,
   output logic [NCH-1:0]        sq_o,
   output logic [NCH-1:0]        pend_o
);

   logic [NCH-1:0] w_wr;

   // Indices at or above NCH match no channel and are dropped.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam ch_idx_t c_IDX = ch_idx_t'(i);

      assign w_wr[i] = div_wr_i && (div_ch_i == c_IDX);

      frq_div_ch #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .mclk   (mclk),
         .reset  (reset),
         .sync_i (sync_i),
         .en_i   (ch_en_i[i]),
         .wr_i   (w_wr[i]),
         .val_i  (div_val_i),
         .tick_o (tick_o[i]),
         .sq_o   (sq_o[i]),
         .pend_o (pend_o[i])
      );
   end

endmodule : frq_div_prog

`default_nettype wire

// File: tb/tb_frq_div_prog.sv
//------------------------------------------------------------------------------
// Module  : tb_frq_div_prog
// Purpose : Self-checking bench for frq_div_prog against a countdown model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frq_div_prog;

   localparam int NCH     = 4;
   localparam int CNT_W   = 16;
   localparam int DEF_DIV = 9;

   logic             mclk;
   logic             reset;
   logic             sync;
   logic [NCH-1:0]   ch_en;
   logic             div_wr;
   logic [3:0]       div_ch;
   logic [CNT_W-1:0] div_val;
   logic [NCH-1:0]   tick_o;
   logic [NCH-1:0]   sq_o;
   logic [NCH-1:0]   pend_o;

   int n_chk;
   int n_fail;

   // Model keeps cycles-remaining-to-wrap rather than an up-counter.
   int             m_rem [NCH];
   int             m_act [NCH];
   int             m_shd [NCH];
   logic [NCH-1:0] m_pend;
   logic [NCH-1:0] m_sq;
   logic [NCH-1:0] m_tick;

   frq_div_prog #(
      .NCH     (NCH),
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .mclk      (mclk),
      .reset     (reset),
      .sync_i    (sync),
      .ch_en_i   (ch_en),
      .div_wr_i  (div_wr),
      .div_ch_i  (div_ch),
      .div_val_i (div_val),
      .tick_o    (tick_o),
      .sq_o      (sq_o),
      .pend_o    (pend_o)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_rem[i] = DEF_DIV;
         m_act[i] = DEF_DIV;
         m_shd[i] = DEF_DIV;
      end
      m_pend = '0;
      m_sq   = '0;
      m_tick = '0;
   endtask

   task automatic model_step();
      for (int i = 0; i < NCH; i++) begin
         m_tick[i] = 1'b0;
         if (sync) begin
            if (m_pend[i]) m_act[i] = m_shd[i];
            m_pend[i] = 1'b0;
            m_rem[i]  = m_act[i];
            m_sq[i]   = 1'b0;
         end else if (!ch_en[i]) begin
            if (m_pend[i]) begin
               m_act[i]  = m_shd[i];
               m_rem[i]  = m_act[i];
               m_pend[i] = 1'b0;
            end
         end else if (m_rem[i] == 0) begin
            m_tick[i] = 1'b1;
            m_sq[i]   = ~m_sq[i];
            if (m_pend[i]) begin
               m_act[i]  = m_shd[i];
               m_pend[i] = 1'b0;
            end
            m_rem[i] = m_act[i];
         end else begin
            m_rem[i] = m_rem[i] - 1;
         end
         if (div_wr && (int'(div_ch) == i)) begin
            m_shd[i]  = int'(div_val);
            m_pend[i] = 1'b1;
         end
      end
   endtask

   // One clock: advance model, let the edge pass, compare, clear pulses.
   task automatic step();
      model_step();
      @(posedge mclk);
      #1;
      check_eq("tick", 32'(tick_o), 32'(m_tick));
      check_eq("sq",   32'(sq_o),   32'(m_sq));
      check_eq("pend", 32'(pend_o), 32'(m_pend));
      div_wr = 1'b0;
      sync   = 1'b0;
   endtask

   task automatic write_div(input int ch, input int val);
      div_wr  = 1'b1;
      div_ch  = 4'(ch);
      div_val = CNT_W'(val);
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      reset   = 1'b1;
      sync    = 1'b0;
      ch_en   = '0;
      div_wr  = 1'b0;
      div_ch  = '0;
      div_val = '0;
      model_reset();

      repeat (2) @(posedge mclk);
      #1;
      check_eq("rst_tick", 32'(tick_o), 32'd0);
      check_eq("rst_sq",   32'(sq_o),   32'd0);
      check_eq("rst_pend", 32'(pend_o), 32'd0);
      reset = 1'b0;

      // Default divisor: ticks on cycles 10/20/30, sq high for 10..19.
      ch_en = 4'b0001;
      for (int c = 1; c <= 30; c++) begin
         step();
         check_eq("def_tick0", 32'(tick_o[0]), 32'(c % 10 == 0));
         check_eq("def_sq0",   32'(sq_o[0]),   32'((c / 10) % 2 == 1));
      end

      // Pending write, then asynchronous reset at count 6 with sq high.
      for (int c = 31; c <= 36; c++) begin
         if (c == 31) write_div(0, 9);
         step();
      end
      check_eq("pre_rst_sq0",   32'(sq_o[0]),   32'd1);
      check_eq("pre_rst_pend0", 32'(pend_o[0]), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("async_tick", 32'(tick_o), 32'd0);
      check_eq("async_sq",   32'(sq_o),   32'd0);
      check_eq("async_pend", 32'(pend_o), 32'd0);
      model_reset();
      repeat (2) @(posedge mclk);
      #1;
      reset = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         step();
         check_eq("rerst_tick0", 32'(tick_o[0]), 32'(c % 10 == 0));
         check_eq("rerst_sq0",   32'(sq_o[0]),   32'((c / 10) % 2 == 1));
      end

      // D=0 on a disabled channel is applied at once; then ticks every cycle.
      write_div(2, 0);
      step();
      check_eq("d0_pend_set", 32'(pend_o[2]), 32'd1);
      step();
      check_eq("d0_pend_clr", 32'(pend_o[2]), 32'd0);
      ch_en = 4'b0101;
      for (int k = 1; k <= 4; k++) begin
         step();
         check_eq("d0_tick2", 32'(tick_o[2]), 32'd1);
         check_eq("d0_sq2",   32'(sq_o[2]),   32'(k % 2));
      end

      // D=4 on ch1 and D=6 on ch3, free-run, then sync.
      write_div(1, 4);
      step();
      write_div(3, 6);
      step();
      step();
      ch_en = 4'b1111;
      repeat (13) step();
      sync = 1'b1;
      step();
      check_eq("sync_sq",   32'(sq_o),   32'd0);
      check_eq("sync_tick", 32'(tick_o), 32'd0);
      for (int k = 1; k <= 7; k++) begin
         step();
         check_eq("sync_tick1", 32'(tick_o[1]), 32'(k == 5));
         check_eq("sync_tick3", 32'(tick_o[3]), 32'(k == 7));
      end

      // Out-of-range channel index touches nothing.
      write_div(NCH, 1);
      step();
      check_eq("oor_pend", 32'(pend_o), 32'd0);

      // Write coincident with a wrap is held over to the following wrap.
      for (int k = 0; k < 10 && m_rem[1] != 0; k++) step();
      check_eq("wrap_found", 32'(m_rem[1] == 0), 32'd1);
      write_div(1, 2);
      step();
      check_eq("coin_tick1", 32'(tick_o[1]), 32'd1);
      check_eq("coin_pend1", 32'(pend_o[1]), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         step();
         check_eq("coin_old_tick1", 32'(tick_o[1]), 32'(k == 5));
      end
      check_eq("coin_pend1_clr", 32'(pend_o[1]), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         step();
         check_eq("coin_new_tick1", 32'(tick_o[1]), 32'(k == 3));
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < NCH; i++) ch_en[i] = ($urandom_range(0, 7) != 0);
         sync = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 3) == 0) write_div($urandom_range(0, 5), $urandom_range(0, 7));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule : tb_frq_div_prog

`default_nettype wire
